piso_tx: RTL

Parallel-in, serial-out transmitter: the sending end of the word-wide enabled-register path. A `WIDTH`-bit word is captured on a load handshake and shifted out LSB-first, one bit per clock, with a frame-valid qualifier. It sits between a parallel datapath register and a serial link whose receiver samples `sout` while `sout_valid` is high. It is the transmit counterpart of the team's enabled-capture registers.

---
 rtl/piso_tx_pkg.sv | 26 ++
 rtl/piso_tx_if.sv | 45 ++++
 rtl/piso_tx_shreg.sv | 43 ++++
 rtl/piso_tx.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// -----------------------------------------------------------------------------
// piso_tx_pkg
// Shared definitions for the piso_tx parallel-in / serial-out transmitter:
// the default word width, the load-enable polarity and the FSM state type.
// Configuration macro: PARITY_EN adds the PARITY state to the state type.
// -----------------------------------------------------------------------------
package piso_tx_pkg;

    // Default data word width (must be >= 2).
    localparam int DEF_WIDTH = 8;

    // Polarity of the load request.
    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Transmitter states. PARITY exists only when the parity bit is built in.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1
`ifdef PARITY_EN
        ,
        S_PARITY = 2'd2
`endif
    } state_e;

endpackage

// File: rtl/piso_tx_if.sv
// -----------------------------------------------------------------------------
// piso_tx_if
// Bundles the load handshake and the serial link outputs of piso_tx.
//   d          parallel word to transmit (master -> slave)
//   load       load request, active at ENABLE (master -> slave)
//   ready      a load will be accepted (slave -> master)
//   sout       serial data bit (slave -> master)
//   sout_valid a frame bit is on sout (slave -> master)
//   busy       a frame is in progress (slave -> master)
//   done       one-cycle pulse after the last frame bit (slave -> master)
// Configuration macro: PARITY_EN (no effect on this interface).
// -----------------------------------------------------------------------------
interface piso_tx_if import piso_tx_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] d;
    logic             load;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    // Word source side: drives the word and the load request.
    modport master (
        output d,
        output load,
        input  ready,
        input  sout,
        input  sout_valid,
        input  busy,
        input  done
    );

    // Transmitter side.
    modport slave (
        input  d,
        input  load,
        output ready,
        output sout,
        output sout_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_tx_shreg.sv
// -----------------------------------------------------------------------------
// piso_tx_shreg
// WIDTH-bit loadable right-shift register (zero fill) with asynchronous
// active-low clear. Load has priority over shift. Only the LSB leaves the
// block because the transmitter serializes LSB-first.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low clear
//   i_load  capture i_d
//   i_shift shift right by one, zero into the MSB
//   i_d     parallel word
//   o_lsb   current bit 0
// Configuration macro: PARITY_EN (no effect on this block).
// -----------------------------------------------------------------------------
module piso_tx_shreg import piso_tx_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_d,
    output logic             o_lsb
);

    logic [WIDTH-1:0] r_q;

    // Shift register: clear, load, or shift right with zero fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_q <= i_d;
        end else if (i_shift) begin
            r_q <= {1'b0, r_q[WIDTH-1:1]};
        end else begin
            r_q <= r_q;
        end
    end

    assign o_lsb = r_q[0];

endmodule

// File: rtl/piso_tx.sv
// -----------------------------------------------------------------------------
// piso_tx
// Parallel-in, serial-out transmitter. A WIDTH-bit word is captured on an
// accepted load and sent LSB-first, one bit per clock, with sout_valid high
// for every frame bit. done pulses for one cycle in the first idle cycle after
// a frame, and a new load may be accepted in that same cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (also aborts a frame in flight)
//   bus    piso_tx_if.slave: d, load in; ready, sout, sout_valid, busy, done out
// Configuration macro: PARITY_EN -- when defined an even-parity bit (XOR of
// the captured word) follows the MSB and the frame is WIDTH+1 cycles long.
// All outputs are decoded from registered state only.
// -----------------------------------------------------------------------------
module piso_tx import piso_tx_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    piso_tx_if.slave  bus
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_e        r_state;
    state_e        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_load_en;
    logic          w_shift_en;
    logic          w_cnt_inc;
    logic          w_lsb;

`ifdef PARITY_EN
    logic          r_parity;

    // Even parity of a word: 1 when the word holds an odd number of ones.
    function automatic logic even_parity(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction
`endif

    piso_tx_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load_en),
        .i_shift (w_shift_en),
        .i_d     (bus.d),
        .o_lsb   (w_lsb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and datapath controls.
    always_comb begin
        w_state_nxt = r_state;
        w_load_en   = 1'b0;
        w_shift_en  = 1'b0;
        w_cnt_inc   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Loads are only seen here, so a load during a frame is dropped.
                if (bus.load == ENABLE) begin
                    w_load_en   = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SHIFT: begin
                w_shift_en = 1'b1;
                if (r_cnt == LAST_CNT) begin
                    // Counter holds at its last value, so it never wraps.
`ifdef PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
`endif
                end else begin
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
`ifdef PARITY_EN
            S_PARITY: begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
`endif
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Bit counter: cleared on an accepted load, advanced once per data bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CW{1'b0}};
        end else if (w_load_en) begin
            r_cnt <= {CW{1'b0}};
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

`ifdef PARITY_EN
    // Parity is computed from d at the accepting edge so later d changes
    // cannot affect the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_load_en) begin
            r_parity <= even_parity(bus.d);
        end else begin
            r_parity <= r_parity;
        end
    end
`endif

    // done pulse: high only in the cycle after the return to IDLE edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
        end
    end

    // Output decode from registered state; sout is held at 0 outside a frame.
    always_comb begin
        bus.ready      = 1'b0;
        bus.busy       = 1'b0;
        bus.sout_valid = 1'b0;
        bus.sout       = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.ready = 1'b1;
            end
            S_SHIFT: begin
                bus.busy       = 1'b1;
                bus.sout_valid = 1'b1;
                bus.sout       = w_lsb;
            end
`ifdef PARITY_EN
            S_PARITY: begin
                bus.busy       = 1'b1;
                bus.sout_valid = 1'b1;
                bus.sout       = r_parity;
            end
`endif
            default: begin
                bus.ready = 1'b1;
            end
        endcase
    end

    assign bus.done = r_done;

endmodule
